// File: rtl/dac_dma_pkg.sv
// Shared constants, FSM state type and burst-sizing helper for the DAC playback DMA read path.
package dac_dma_pkg;

  localparam int         BYTES_PER_BEAT = 16;
  localparam int         BOUNDARY_4K    = 4096;
  localparam logic [2:0] ARSIZE_128B    = 3'b100;
  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [3:0] ARCACHE_MOD    = 4'b0011;
  localparam logic [2:0] ARPROT_NONE    = 3'b000;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Beats for the next burst: bounded by max burst, remaining beats and the next 4 KB page edge.
  function automatic logic [8:0] burst_beats(input logic [11:0] page_off,
                                             input logic [27:0] rem,
                                             input int          max_len);
    logic [31:0] to_bnd;
    logic [31:0] lim;
    to_bnd = (32'(BOUNDARY_4K) - {20'd0, page_off}) >> 4;
    lim    = ({4'd0, rem} < 32'(max_len)) ? {4'd0, rem} : 32'(max_len);
    lim    = (to_bnd < lim) ? to_bnd : lim;
    return lim[8:0];
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO; head entry is visible on rd_data whenever not empty.
module sync_fwft_fifo
  #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
  )
  (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic [CNT_W-1:0]  count
  );

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              do_rd_s;

  assign do_rd_s = rd_en & (count_r != {CNT_W{1'b0}});
  assign rd_data = mem_r[rd_ptr_r];
  assign empty   = (count_r == {CNT_W{1'b0}});
  assign count   = count_r;

  // Storage array; writers are never blocked because the upstream credit scheme prevents overflow.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous write and read leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_en) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_en, do_rd_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dac_dma_rd.sv
// AXI4 read master fetching a playback buffer from DDR and streaming it out as AXI-Stream.
// Bursts are issued only against reserved FIFO space, so the R channel is never stalled.
module dac_dma_rd
  import dac_dma_pkg::*;
  #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 128,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_OUTST  = 4
  )
  (
    input  logic              ps_clk,
    input  logic              ps_rstb,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [31:0]       play_size,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              play_done,
    output logic              rd_err,
    output logic [31:0]       current_addr,
    output logic [7:0]        loop_count
  );

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] base_r, addr_r, araddr_r;
  logic [27:0]       total_beats_r, rem_r, rd_beat_cnt_r;
  logic [7:0]        arlen_r, loop_count_r;
  logic [OUT_W-1:0]  outst_r;
  logic [CNT_W-1:0]  reserved_r;
  logic              arvalid_r, stop_req_r, busy_r, play_done_r, rd_err_r, rready_r;

  logic [27:0]       total_in_s;
  logic [8:0]        len_s, len_m1_s, ar_beats_s;
  logic [31:0]       credit_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_empty_s, tvalid_s, pass_end_s;
  logic              ar_hs_s, r_hs_s, rlast_hs_s, t_hs_s;
  logic              issue_s, start_acc_s, loop_restart_s, drained_s;
  logic              unused_s;

  assign unused_s    = ^{start_address[3:0], play_size[3:0]};
  assign total_in_s  = play_size[31:4];
  assign ar_hs_s     = arvalid_r & m_axi_arready;
  assign r_hs_s      = m_axi_rvalid & rready_r;
  assign rlast_hs_s  = r_hs_s & m_axi_rlast;
  assign tvalid_s    = ~fifo_empty_s;
  assign t_hs_s      = tvalid_s & m_axis_tready;
  assign pass_end_s  = (rd_beat_cnt_r == (total_beats_r - 28'd1));
  assign drained_s   = (outst_r == {OUT_W{1'b0}}) & fifo_empty_s;
  assign ar_beats_s  = {1'b0, arlen_r} + 9'd1;

  assign len_s    = burst_beats(addr_r[11:0], rem_r, BURST_LEN);
  assign len_m1_s = len_s - 9'd1;
  // Free FIFO space not already promised to bursts in flight.
  assign credit_s = 32'(FIFO_DEPTH) - 32'(fifo_count_s) - 32'(reserved_r);
  assign issue_s  = (state_r == RUN) & ~arvalid_r & (rem_r != 28'd0) & ~stop_req_r &
                    (credit_s >= {23'd0, len_s}) & (32'(outst_r) < 32'(MAX_OUTST));

  assign start_acc_s    = (state_r == IDLE) & play_start & (total_in_s != 28'd0);
  assign loop_restart_s = (state_r == DRAIN) & (state_s == RUN);

  sync_fwft_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ps_clk),
    .rst_n   (ps_rstb),
    .wr_en   (r_hs_s),
    .wr_data (m_axi_rdata),
    .rd_en   (m_axis_tready),
    .rd_data (m_axis_tdata),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Next-state selection for the playback sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_acc_s) state_s = RUN;
        else             state_s = IDLE;
      end
      RUN: begin
        if (!arvalid_r && (stop_req_r || rem_r == 28'd0)) state_s = DRAIN;
        else                                                 state_s = RUN;
      end
      DRAIN: begin
        if (drained_s) begin
          if (loop_en && !stop_req_r) state_s = RUN;
          else                        state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Sequencer state, status flags and pass bookkeeping.
  always_ff @(posedge ps_clk or negedge ps_rstb) begin
    if (!ps_rstb) begin
      state_r       <= IDLE;
      busy_r        <= 1'b0;
      play_done_r   <= 1'b0;
      rready_r      <= 1'b0;
      stop_req_r    <= 1'b0;
      rd_err_r      <= 1'b0;
      base_r        <= {ADDR_W{1'b0}};
      addr_r        <= {ADDR_W{1'b0}};
      total_beats_r <= 28'd0;
      rem_r         <= 28'd0;
      loop_count_r  <= 8'd0;
      rd_beat_cnt_r <= 28'd0;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != IDLE);
      rready_r    <= 1'b1;
      play_done_r <= (state_r == DONE) |
                     ((state_r == IDLE) & play_start & (total_in_s == 28'd0));

      if (state_r == IDLE)  stop_req_r <= 1'b0;
      else if (play_stop)   stop_req_r <= 1'b1;
      else                  stop_req_r <= stop_req_r;

      if (start_acc_s)                                    rd_err_r <= 1'b0;
      else if (r_hs_s && m_axi_rresp != AXI_RESP_OKAY)    rd_err_r <= 1'b1;
      else                                                rd_err_r <= rd_err_r;

      if (start_acc_s) begin
        base_r        <= {start_address[ADDR_W-1:4], 4'b0000};
        addr_r        <= {start_address[ADDR_W-1:4], 4'b0000};
        total_beats_r <= total_in_s;
        rem_r         <= total_in_s;
        loop_count_r  <= 8'd0;
      end else if (loop_restart_s) begin
        addr_r       <= base_r;
        rem_r        <= total_beats_r;
        loop_count_r <= (loop_count_r == 8'hFF) ? 8'hFF : loop_count_r + 8'd1;
      end else if (ar_hs_s) begin
        addr_r <= addr_r + ADDR_W'(ar_beats_s) * ADDR_W'(BYTES_PER_BEAT);
        rem_r  <= rem_r - {19'd0, ar_beats_s};
      end else begin
        addr_r <= addr_r;
        rem_r  <= rem_r;
      end

      // Read-side beat position inside the pass; wraps on the beat that carries tlast.
      if (start_acc_s)     rd_beat_cnt_r <= 28'd0;
      else if (t_hs_s)     rd_beat_cnt_r <= pass_end_s ? 28'd0 : rd_beat_cnt_r + 28'd1;
      else                 rd_beat_cnt_r <= rd_beat_cnt_r;
    end
  end

  // AR channel plus credit accounting for reserved space and outstanding bursts.
  always_ff @(posedge ps_clk or negedge ps_rstb) begin
    if (!ps_rstb) begin
      arvalid_r  <= 1'b0;
      araddr_r   <= {ADDR_W{1'b0}};
      arlen_r    <= 8'd0;
      outst_r    <= {OUT_W{1'b0}};
      reserved_r <= {CNT_W{1'b0}};
    end else begin
      if (issue_s) begin
        arvalid_r <= 1'b1;
        araddr_r  <= addr_r;
        arlen_r   <= len_m1_s[7:0];
      end else if (ar_hs_s) begin
        arvalid_r <= 1'b0;
      end else begin
        arvalid_r <= arvalid_r;
      end
      outst_r    <= outst_r + (ar_hs_s ? OUT_W'(1) : {OUT_W{1'b0}})
                            - (rlast_hs_s ? OUT_W'(1) : {OUT_W{1'b0}});
      reserved_r <= reserved_r + (ar_hs_s ? CNT_W'(ar_beats_s) : {CNT_W{1'b0}})
                               - (r_hs_s ? CNT_W'(1) : {CNT_W{1'b0}});
    end
  end

  assign m_axi_araddr  = araddr_r;
  assign m_axi_arlen   = arlen_r;
  assign m_axi_arsize  = ARSIZE_128B;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arcache = ARCACHE_MOD;
  assign m_axi_arprot  = ARPROT_NONE;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rready_r;
  assign m_axis_tvalid = tvalid_s;
  assign m_axis_tlast  = tvalid_s & pass_end_s;
  assign busy          = busy_r;
  assign play_done     = play_done_r;
  assign rd_err        = rd_err_r;
  assign current_addr  = 32'(addr_r);
  assign loop_count    = loop_count_r;

endmodule

// File: tb/tb_dac_dma_rd.sv
// Randomized bench for dac_dma_rd: DDR slave model plus a queue-based reference of AR bursts and stream beats.
module tb_dac_dma_rd;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [127:0] data; logic last; } beat_t;

  logic         ps_clk = 1'b0;
  logic         ps_rstb = 1'b0;
  logic         play_start = 1'b0, play_stop = 1'b0, loop_en = 1'b0;
  logic [31:0]  start_address = 32'd0, play_size = 32'd0;
  logic [31:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic [3:0]   m_axi_arcache;
  logic [2:0]   m_axi_arprot;
  logic         m_axi_arvalid, m_axi_arready = 1'b0;
  logic [127:0] m_axi_rdata = 128'd0;
  logic [1:0]   m_axi_rresp = 2'b00;
  logic         m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
  logic         busy, play_done, rd_err;
  logic [31:0]  current_addr;
  logic [7:0]   loop_count;

  int n_checks = 0, n_errors = 0;
  int ar_mode = 0, t_mode = 1, r_idx = 0, err_beat = -1;
  bit r_en = 1'b1;
  int ar_hs_cnt = 0, r_beat_cnt = 0, t_cnt = 0, tlast_cnt = 0;
  ar_t   exp_ar_q[$];
  ar_t   pend_q[$];
  beat_t exp_t_q[$];

  dac_dma_rd dut (
    .ps_clk(ps_clk), .ps_rstb(ps_rstb), .play_start(play_start), .play_stop(play_stop),
    .loop_en(loop_en), .start_address(start_address), .play_size(play_size),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy),
    .play_done(play_done), .rd_err(rd_err), .current_addr(current_addr), .loop_count(loop_count)
  );

  always #2 ps_clk = ~ps_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_word(input logic [31:0] a);
    return {a, a ^ 32'hA5A5_5A5A, ~a, a + 32'h1234_5678};
  endfunction

  // Reference: split a pass into bursts (16 beats max, never across 4 KB) and list the beats it yields.
  task automatic plan_pass(input logic [31:0] base, input logic [31:0] size);
    logic [31:0] a;
    int n, rem, done, len, bnd;
    ar_t ar;
    beat_t bt;
    a = base & 32'hFFFF_FFF0;
    n = int'(size >> 4);
    rem = n;
    done = 0;
    while (rem > 0) begin
      bnd = (4096 - int'(a % 32'd4096)) / 16;
      len = (rem < 16) ? rem : 16;
      if (bnd < len) len = bnd;
      ar.addr = a;
      ar.len  = 8'(len - 1);
      exp_ar_q.push_back(ar);
      for (int i = 0; i < len; i++) begin
        bt.data = mem_word(a + 32'(i * 16));
        bt.last = (done + i == n - 1);
        exp_t_q.push_back(bt);
      end
      a += 32'(len * 16);
      rem -= len;
      done += len;
    end
  endtask

  // DDR slave and AXIS sink: inputs change #1 after each edge, transfers are scored for the next edge.
  initial begin : bus_model
    ar_t cur;
    beat_t bt;
    logic [31:0] ba;
    forever begin
      @(posedge ps_clk);
      #1;
      if (!ps_rstb) begin
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axis_tready = 1'b0;
      end else begin
        m_axi_arready = (ar_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (m_axi_arvalid && m_axi_arready) begin
          ar_hs_cnt++;
          check("ar_fixed", {m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot},
                {3'b100, 2'b01, 4'b0011, 3'b000});
          check("ar_expected", exp_ar_q.size() != 0, 1'b1);
          if (exp_ar_q.size() != 0) begin
            cur = exp_ar_q.pop_front();
            check("araddr", m_axi_araddr, cur.addr);
            check("arlen", m_axi_arlen, cur.len);
          end
          cur.addr = m_axi_araddr;
          cur.len  = m_axi_arlen;
          pend_q.push_back(cur);
        end
        if (r_en && pend_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          ba = pend_q[0].addr + 32'(r_idx) * 32'd16;
          m_axi_rdata  = mem_word(ba);
          m_axi_rlast  = (r_idx == int'(pend_q[0].len));
          m_axi_rresp  = (r_beat_cnt == err_beat) ? 2'b10 : 2'b00;
          m_axi_rvalid = 1'b1;
          if (m_axi_rready) begin
            r_beat_cnt++;
            if (m_axi_rlast) begin
              pend_q.delete(0);
              r_idx = 0;
            end else begin
              r_idx++;
            end
          end
        end else begin
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
          m_axi_rresp  = 2'b00;
        end
        m_axis_tready = (t_mode == 1) ? 1'b1 : (t_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
        if (m_axis_tvalid && m_axis_tready) begin
          t_cnt++;
          if (m_axis_tlast) tlast_cnt++;
          check("beat_expected", exp_t_q.size() != 0, 1'b1);
          if (exp_t_q.size() != 0) begin
            bt = exp_t_q.pop_front();
            check("tdata", m_axis_tdata, bt.data);
            check("tlast", m_axis_tlast, bt.last);
          end
        end
      end
    end
  end

  task automatic start_play(input logic [31:0] base, input logic [31:0] size, input logic lp);
    plan_pass(base, size);
    @(posedge ps_clk);
    #1;
    start_address = base;
    play_size     = size;
    loop_en       = lp;
    play_start    = 1'b1;
    @(posedge ps_clk);
    #1;
    play_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge ps_clk);
      #1;
      if (play_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("ar_left", exp_ar_q.size(), 0);
    check("beats_left", exp_t_q.size(), 0);
    @(posedge ps_clk);
    #1;
    check("done_pulse_width", play_done, 1'b0);
  endtask

  task automatic wait_count(input string tag, input int which, input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge ps_clk);
      #1;
      if ((which == 0 ? ar_hs_cnt : tlast_cnt) >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1'b1);
  endtask

  initial begin : main
    logic [31:0] base, size;
    int a0, tl0, c0;

    repeat (3) @(posedge ps_clk);
    #1;
    check("rst_rready", m_axi_rready, 1'b0);
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_status", {busy, play_done, rd_err, loop_count, current_addr}, 43'd0);
    @(negedge ps_clk);
    ps_rstb = 1'b1;
    @(posedge ps_clk);
    #1;
    check("post_rst_rready", m_axi_rready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    // single pass, always-ready sink
    t_mode = 1; ar_mode = 0;
    start_play(32'h1000_0000, 32'd256, 1'b0);
    check("single_busy", busy, 1'b1);
    tl0 = tlast_cnt; c0 = t_cnt;
    wait_done(2000);
    check("single_beats", t_cnt - c0, 16);
    check("single_tlast", tlast_cnt - tl0, 1);
    check("single_loop_count", loop_count, 8'd0);
    check("single_cur_addr", current_addr, 32'h1000_0100);

    // 4 KB page split
    t_mode = 0;
    a0 = ar_hs_cnt;
    start_play(32'h0000_0FF0, 32'd64, 1'b0);
    wait_done(2000);
    check("split_ar_count", ar_hs_cnt - a0, 2);

    // zero-beat request
    start_play(32'h0000_2000, 32'd15, 1'b0);
    check("zero_done", play_done, 1'b1);
    check("zero_busy", busy, 1'b0);

    // back-pressure: sink stalled, credits must cap issue at FIFO depth
    ar_mode = 1; t_mode = 2;
    a0 = ar_hs_cnt;
    start_play(32'h2000_0000, 32'd4096, 1'b0);
    repeat (200) @(posedge ps_clk);
    #1;
    check("bp_ar_count", ar_hs_cnt - a0, 4);
    check("bp_arvalid", m_axi_arvalid, 1'b0);
    check("bp_tvalid", m_axis_tvalid, 1'b1);
    t_mode = 1;
    wait_done(4000);
    ar_mode = 0;

    // loop playback, stop once the fourth pass has its burst issued
    t_mode = 0;
    plan_pass(32'h3000_0040, 32'd32);
    plan_pass(32'h3000_0040, 32'd32);
    plan_pass(32'h3000_0040, 32'd32);
    tl0 = tlast_cnt; a0 = ar_hs_cnt; c0 = t_cnt;
    start_play(32'h3000_0040, 32'd32, 1'b1);
    wait_count("loop_third_tlast", 1, tl0 + 3, 3000);
    wait_count("loop_fourth_ar", 0, a0 + 4, 3000);
    play_stop = 1'b1;
    @(posedge ps_clk);
    #1;
    play_stop = 1'b0;
    wait_done(3000);
    loop_en = 1'b0;
    check("loop_count", loop_count, 8'd3);
    check("loop_tlasts", tlast_cnt - tl0, 4);
    check("loop_beats", t_cnt - c0, 8);
    check("loop_cur_addr", current_addr, 32'h3000_0060);

    // read error is sticky through done and cleared by the next start
    err_beat = r_beat_cnt + 3;
    c0 = t_cnt;
    start_play(32'h4000_0100, 32'd128, 1'b0);
    wait_done(2000);
    check("err_sticky", rd_err, 1'b1);
    check("err_beats", t_cnt - c0, 8);
    err_beat = -1;
    start_play(32'h4000_0800, 32'd64, 1'b0);
    check("err_cleared", rd_err, 1'b0);
    wait_done(2000);
    check("err_clean_pass", rd_err, 1'b0);

    // asynchronous reset with bursts in flight
    ar_mode = 1; t_mode = 2; r_en = 1'b0;
    a0 = ar_hs_cnt;
    start_play(32'h5000_0000, 32'd4096, 1'b0);
    wait_count("rst_two_outstanding", 0, a0 + 2, 200);
    @(negedge ps_clk);
    ps_rstb = 1'b0;
    #1;
    check("mid_rst_ar", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, 41'd0);
    check("mid_rst_stream", {m_axis_tvalid, m_axis_tlast, m_axi_rready}, 3'd0);
    check("mid_rst_status", {busy, play_done, rd_err, loop_count, current_addr}, 43'd0);
    exp_ar_q.delete();
    exp_t_q.delete();
    pend_q.delete();
    r_idx = 0;
    r_en = 1'b1; ar_mode = 0; t_mode = 0;
    repeat (3) @(negedge ps_clk);
    ps_rstb = 1'b1;
    start_play(32'h5000_0F00, 32'd512, 1'b0);
    wait_done(4000);

    // randomized passes with random handshakes
    for (int k = 0; k < 6; k++) begin
      base = $urandom();
      base[31] = 1'b0;
      base[11:0] = 12'($urandom_range(3840, 4095));
      size = $urandom_range(16, 1024);
      c0 = t_cnt;
      start_play(base, size, 1'b0);
      wait_done(6000);
      check("rand_beats", t_cnt - c0, int'(size >> 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dac_dma_rd.md
Name: dac_dma_rd

Overview:
- AXI4 read master that fetches a playback buffer from PS DDR and emits it as a 128-bit AXI-Stream toward the DAC data path.
- Read-side counterpart of the capture write path; sits between PS HP port and the DAC width/reorder/CDC stages.
- Credit-based burst issue with an internal sync FIFO, so R data is never back-pressured. Optional loop playback.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 128, AXI/AXIS data width (bytes per beat = DATA_W/8 = 16)
BURST_LEN, 16, max beats per AR burst
FIFO_DEPTH, 64, sync FIFO entries (>= 2*BURST_LEN, power of 2)
MAX_OUTST, 4, max outstanding AR bursts

Ports:
ps_clk  in  1  AXI/AXIS clock, 333.25 MHz
ps_rstb  in  1  async active-low reset
play_start  in  1  1-cycle pulse, begin playback
play_stop  in  1  1-cycle pulse, request stop
loop_en  in  1  repeat buffer until stopped
start_address  in  ADDR_W  buffer base, byte address
play_size  in  32  buffer size, bytes
m_axi_araddr  out  ADDR_W  read address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  fixed 3'b100
m_axi_arburst  out  2  fixed INCR (2'b01)
m_axi_arcache  out  4  fixed 4'b0011
m_axi_arprot  out  3  fixed 0
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rdata  in  DATA_W  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axis_tdata  out  DATA_W  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  last beat of a buffer pass
busy  out  1  FSM not IDLE
play_done  out  1  1-cycle pulse on return to IDLE
rd_err  out  1  sticky, any rresp != OKAY
current_addr  out  32  next AR address
loop_count  out  8  completed passes, saturates at 255

Behaviour:
- Clock/reset: single clock ps_clk; ps_rstb asynchronous, active-low.
- Reset values: arvalid=0, araddr=0, arlen=0, tvalid=0, tlast=0, busy=0, play_done=0, rd_err=0, current_addr=0, loop_count=0. FIFO is emptied. Credits are cleared. rready=0 during reset, 1 otherwise.
- Sizing: start_address[3:0] and play_size[3:0] are ignored (truncated). total_beats = play_size>>4. Both are latched on play_start.
- FSM IDLE:
  - play_start with total_beats!=0 -> RUN. Clear rd_err and loop_count; addr=base; rem=total_beats.
  - play_start with total_beats==0 -> stay IDLE, pulse play_done next cycle.
- FSM RUN:
  - Burst length = min(BURST_LEN, rem, beats to next 4 KB boundary).
  - Raise arvalid only if both hold: FIFO free - reserved >= len, and outstanding < MAX_OUTST.
  - araddr/arlen are held stable while arvalid && !arready.
  - On handshake: reserved += len; addr += len*16; rem -= len; outstanding++.
  - rem==0 -> DRAIN.
- FSM DRAIN: wait until outstanding==0 and the last beat of the pass has left the AXIS port.
  - If loop_en && !stop_req: loop_count++, addr=base, rem=total_beats -> RUN.
  - Otherwise -> DONE.
- FSM DONE: play_done=1 for one cycle -> IDLE.
- play_stop in RUN: sets stop_req. No new AR after the current handshake completes; go to DRAIN. In-flight data is still streamed. stop_req clears in IDLE. play_stop in IDLE is ignored. play_start while busy is ignored.
- R channel:
  - Every rvalid beat is written to the FIFO; reserved-- and the written beat is counted.
  - outstanding-- on rlast.
  - rresp != 2'b00 -> rd_err=1 (sticky); data is still forwarded.
- tlast: asserted on the FIFO beat that completes total_beats within a pass. Tracked by a per-pass beat counter on the read side.
- AXIS: standard valid/ready. tdata/tlast held while tvalid && !tready. FIFO read latency is 0 (FWFT). R-beat-to-tvalid latency is 1 cycle.
- Simultaneous events:
  - Same-cycle AR issue and R beat update reserved correctly (+len-1).
  - Same-cycle FIFO write and read leave the count unchanged.
- Wrap: 4 KB split guarantees no burst crosses a 4 KB boundary.
- current_addr = addr register.

Decomposition:
- Package dac_dma_pkg: BYTES_PER_BEAT, ARSIZE_128B, BURST_INCR, AXI_RESP_OKAY, state enum (IDLE, RUN, DRAIN, DONE), 4 KB boundary constant.
- One sub-module, sync_fwft_fifo (DATA_W+0 wide, FIFO_DEPTH deep, count output). tlast is generated outside it.

Test Plan:
- Single pass: base 0x1000_0000, size 256, tready=1 -> one AR arlen=15; 16 AXIS beats, tlast on beat 16; play_done 1 cycle after drain; loop_count=0.
- 4 KB split: base 0x0000_0FF0, size 64 -> AR#1 araddr 0x0FF0 arlen=0; AR#2 araddr 0x1000 arlen=2; 4 beats out in order.
- Back-pressure: size 4096, tready=0, arready=1 -> exactly FIFO_DEPTH/BURST_LEN=4 ARs issued, then arvalid=0. No FIFO overflow. Release tready -> all 256 beats out in order.
- Loop: size 32, loop_en=1, play_stop after 3rd tlast -> loop_count=3 or 4 per stop timing; final pass completes with tlast; busy drops; play_done pulses.
- Error: rresp=SLVERR on one beat -> rd_err=1 and stays 1 through play_done; cleared by the next play_start; data count unaffected.
- Reset mid-burst: assert ps_rstb low during RUN with 2 bursts outstanding -> all outputs take reset values immediately; a fresh play_start plays cleanly.
